// File: rtl/adc_noise_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : adc_noise_sched_if
// Description : Control, PRNG-handshake and per-channel output bundle for
//               adc_noise_sched.
// Revision    : 1.0 - initial release
// ============================================================================
interface adc_noise_sched_if #(
    parameter int NCH = 4,
    parameter int RW  = 13
);
    logic              enable;
    logic [RW-1:0]     rnd_in;
    logic              rnd_valid;
    logic              rnd_ready;
    logic              clear_starve;
    logic [NCH*RW-1:0] rnd_out;
    logic [NCH-1:0]    strobe;
    logic              running;
    logic [15:0]       starve_cnt;

    modport master (
        output enable, rnd_in, rnd_valid, clear_starve,
        input  rnd_ready, rnd_out, strobe, running, starve_cnt
    );

    modport slave (
        input  enable, rnd_in, rnd_valid, clear_starve,
        output rnd_ready, rnd_out, strobe, running, starve_cnt
    );
endinterface
`default_nettype wire

// File: rtl/adc_noise_sched.sv
`default_nettype none
// ============================================================================
// Module      : adc_noise_sched
// Description : Round-robin distributor of one PRNG stream to NCH emulated
//               ADC channels, with a PRNG-independent strobe cadence.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_noise_sched #(
    parameter int NCH = 4,
    parameter int RW  = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    adc_noise_sched_if.slave     bus
);
    localparam int              c_IW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [c_IW-1:0] c_LAST = c_IW'(NCH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_IW-1:0]   r_ch;
    logic [NCH*RW-1:0] r_slots;
    logic [NCH-1:0]    r_strobe;
    logic              r_running;
    logic [15:0]       r_starve;

    logic w_active;
    logic w_starve_inc;

    // Ready is the only unregistered output: it must drop in the same cycle enable does.
    assign w_active      = bus.enable && (r_state != ST_IDLE);
    assign bus.rnd_ready = w_active;
    assign w_starve_inc  = bus.enable && (r_state == ST_RUN) && !bus.rnd_valid;

    assign bus.rnd_out    = r_slots;
    assign bus.strobe     = r_strobe;
    assign bus.running    = r_running;
    assign bus.starve_cnt = r_starve;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ch      <= '0;
            r_slots   <= '0;
            r_strobe  <= '0;
            r_running <= 1'b0;
            r_starve  <= '0;
        end else begin
            r_strobe <= '0;

            if (bus.clear_starve) begin
                r_starve <= '0;
            end else if (w_starve_inc && (r_starve != 16'hFFFF)) begin
                r_starve <= r_starve + 16'd1;
            end

            case (r_state)
                ST_PRIME: begin
                    if (!bus.enable) begin
                        r_state <= ST_IDLE;
                        r_ch    <= '0;
                        r_slots <= '0;
                    end else if (bus.rnd_valid) begin
                        r_slots[int'(r_ch)*RW +: RW] <= bus.rnd_in;
                        if (r_ch == c_LAST) begin
                            r_ch      <= '0;
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end else begin
                            r_ch <= r_ch + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (!bus.enable) begin
                        r_state   <= ST_IDLE;
                        r_ch      <= '0;
                        r_slots   <= '0;
                        r_running <= 1'b0;
                    end else begin
                        // A missing word zeroes the slot rather than delaying the strobe.
                        r_slots[int'(r_ch)*RW +: RW] <= bus.rnd_valid ? bus.rnd_in : '0;
                        r_strobe[r_ch]               <= 1'b1;
                        r_ch                         <= (r_ch == c_LAST) ? '0 : r_ch + 1'b1;
                    end
                end
                default: begin
                    r_ch      <= '0;
                    r_slots   <= '0;
                    r_running <= 1'b0;
                    if (bus.enable) begin
                        r_state <= ST_PRIME;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_adc_noise_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_noise_sched
// Description : Directed and randomized checks of adc_noise_sched against a
//               cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_noise_sched;
    localparam int NCH = 4;
    localparam int RW  = 13;

    logic clk;
    logic rst;

    adc_noise_sched_if #(.NCH(NCH), .RW(RW)) bus ();

    adc_noise_sched #(.NCH(NCH), .RW(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Model: 0 = idle, 1 = prime, 2 = run
    int             m_mode;
    int             m_idx;
    int             m_starve;
    logic [RW-1:0]  m_slot [NCH];
    logic [NCH-1:0] m_strobe;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode   = 0;
        m_idx    = 0;
        m_starve = 0;
        m_strobe = '0;
        for (int k = 0; k < NCH; k++) m_slot[k] = '0;
    endtask

    task automatic model_idle();
        m_mode = 0;
        m_idx  = 0;
        for (int k = 0; k < NCH; k++) m_slot[k] = '0;
    endtask

    task automatic model_edge();
        logic starve;
        starve   = (m_mode == 2) && bus.enable && !bus.rnd_valid;
        m_strobe = '0;
        if (bus.clear_starve) m_starve = 0;
        else if (starve && m_starve < 65535) m_starve++;
        case (m_mode)
            0: if (bus.enable) m_mode = 1;
            1: begin
                if (!bus.enable) model_idle();
                else if (bus.rnd_valid) begin
                    m_slot[m_idx] = bus.rnd_in;
                    if (m_idx == NCH - 1) begin
                        m_idx  = 0;
                        m_mode = 2;
                    end else m_idx++;
                end
            end
            default: begin
                if (!bus.enable) model_idle();
                else begin
                    m_slot[m_idx]   = bus.rnd_valid ? bus.rnd_in : '0;
                    m_strobe[m_idx] = 1'b1;
                    m_idx           = (m_idx + 1) % NCH;
                end
            end
        endcase
    endtask

    task automatic check_all();
        logic [NCH*RW-1:0] exp_out;
        for (int k = 0; k < NCH; k++) exp_out[k*RW +: RW] = m_slot[k];
        chk("rnd_out", 64'(bus.rnd_out), 64'(exp_out));
        chk("strobe", 64'(bus.strobe), 64'(m_strobe));
        chk("running", 64'(bus.running), 64'(m_mode == 2));
        chk("starve_cnt", 64'(bus.starve_cnt), 64'(m_starve));
        chk("strobe_onehot0", 64'($countones(bus.strobe) <= 1), 64'd1);
    endtask

    task automatic step(input logic e, input logic v, input logic [RW-1:0] d, input logic c);
        bus.enable       = e;
        bus.rnd_valid    = v;
        bus.rnd_in       = d;
        bus.clear_starve = c;
        #1;
        chk("rnd_ready", 64'(bus.rnd_ready), 64'(e && (m_mode != 0)));
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst              = 1'b1;
        bus.enable       = 1'b0;
        bus.rnd_valid    = 1'b0;
        bus.rnd_in       = '0;
        bus.clear_starve = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();

        // Release reset between edges with enable already high.
        #3;
        bus.enable = 1'b1;
        rst        = 1'b0;
        #1;

        // Ordered prime then run with counting data.
        step(1'b1, 1'b1, 13'd1, 1'b0);
        chk("prime_entered_ready", 64'(m_mode), 64'd1);
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, RW'(i), 1'b0);
        chk("prime_slot3", 64'(bus.rnd_out[3*RW +: RW]), 64'd4);
        step(1'b1, 1'b1, 13'd5, 1'b0);
        chk("run_first_strobe", 64'(bus.strobe), 64'b0001);
        chk("run_slot0", 64'(bus.rnd_out[0 +: RW]), 64'd5);
        step(1'b1, 1'b1, 13'd6, 1'b0);
        chk("run_second_strobe", 64'(bus.strobe), 64'b0010);
        chk("run_slot1", 64'(bus.rnd_out[RW +: RW]), 64'd6);

        // Three starved run cycles.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 13'h1ABC, 1'b0);
        chk("starve_three", 64'(bus.starve_cnt), 64'd3);
        chk("starved_slot0", 64'(bus.rnd_out[0 +: RW]), 64'd0);

        // Advance to channel 2, then drop enable.
        step(1'b1, 1'b1, 13'd7, 1'b0);
        chk("at_ch2", 64'(m_idx), 64'd2);
        step(1'b0, 1'b1, 13'd8, 1'b1);
        chk("drop_running", 64'(bus.running), 64'd0);
        chk("drop_slots", 64'(bus.rnd_out), 64'd0);
        chk("drop_strobe", 64'(bus.strobe), 64'd0);

        // Re-enable, load two slots, stall in prime.
        step(1'b1, 1'b1, 13'd9, 1'b0);
        step(1'b1, 1'b1, 13'd21, 1'b0);
        step(1'b1, 1'b1, 13'd22, 1'b0);
        chk("reprime_slot0", 64'(bus.rnd_out[0 +: RW]), 64'd21);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 13'd99, 1'b0);
        chk("prime_stall_starve", 64'(bus.starve_cnt), 64'd0);
        step(1'b1, 1'b1, 13'd23, 1'b0);
        chk("prime_resume_slot2", 64'(bus.rnd_out[2*RW +: RW]), 64'd23);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(logic'($urandom_range(0, 19) != 0), logic'($urandom_range(0, 3) != 0),
                 RW'($urandom), logic'($urandom_range(0, 49) == 0));
        end

        // Reach RUN, then saturate the starve counter.
        for (int i = 0; i < 20 && m_mode != 2; i++) step(1'b1, 1'b1, RW'($urandom), 1'b0);
        chk("reach_run", 64'(m_mode), 64'd2);
        step(1'b1, 1'b0, 13'd0, 1'b1);
        bus.clear_starve = 1'b0;
        repeat (65540) begin
            @(posedge clk);
            model_edge();
        end
        #1;
        check_all();
        chk("starve_saturated", 64'(bus.starve_cnt), 64'd65535);
        step(1'b1, 1'b0, 13'd0, 1'b1);
        chk("starve_cleared", 64'(bus.starve_cnt), 64'd0);

        // Asynchronous reset between edges mid-run.
        step(1'b1, 1'b1, 13'h0777, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("async_rst_strobe", 64'(bus.strobe), 64'd0);
        chk("async_rst_running", 64'(bus.running), 64'd0);
        #10;
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/adc_noise_sched.md
ADC_NOISE_SCHED -- requirements
Module: adc_noise_sched

Interface
REQ-001 Parameter NCH, default 4, number of emulated ADC channels sharing one PRNG stream (2..8).
REQ-002 Parameter RW, default 13, width of the random word delivered to each channel.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 enable  input  1  run request; level-sensitive.
REQ-006 rnd_in  input  RW  random word from the TT800 (or equivalent) PRNG.
REQ-007 rnd_valid  input  1  rnd_in holds a fresh word this cycle.
REQ-008 rnd_ready  output  1  scheduler consumes rnd_in this cycle when rnd_valid is also high.
REQ-009 clear_starve  input  1  synchronous clear of starve_cnt.
REQ-010 rnd_out  output  NCH*RW  per-channel random word; slot k is bits [k*RW+RW-1 : k*RW].
REQ-011 strobe  output  NCH  per-channel strobe; bit k gates channel k's delay line.
REQ-012 running  output  1  high while in RUN.
REQ-013 starve_cnt  output  16  count of RUN-slot cycles without a valid PRNG word.

Function
REQ-014 The block SHALL implement three states: IDLE, PRIME, RUN.
REQ-015 IDLE: rnd_ready=0, strobe=0, running=0, all rnd_out slots zero; enable=1 -> PRIME next cycle.
REQ-016 PRIME: rnd_ready=1, strobe=0; each handshake (rnd_valid&rnd_ready) loads rnd_in into slot ch_idx, then ch_idx increments.
REQ-017 PRIME: no handshake -> ch_idx and slots hold; stalls are not counted in starve_cnt.
REQ-018 PRIME: the handshake that loads slot NCH-1 SHALL move to RUN next cycle with ch_idx wrapped to 0.
REQ-019 RUN: rnd_ready=1 every cycle; running=1.
REQ-020 RUN, rnd_valid=1: slot ch_idx <= rnd_in; strobe[ch_idx] pulses for one cycle.
REQ-021 RUN, rnd_valid=0: slot ch_idx <= 0; strobe[ch_idx] still pulses; starve_cnt increments. Strobe timing SHALL NOT depend on the PRNG.
REQ-022 RUN: ch_idx increments every cycle; it wraps from NCH-1 to 0. Each channel therefore strobes exactly once per NCH cycles, in channel order.
REQ-023 Latency: a word accepted in cycle n SHALL appear on its rnd_out slot in cycle n+1. The matching strobe bit SHALL be high in cycle n+1 only.
REQ-024 At most one strobe bit SHALL be high in any cycle.
REQ-025 Slots not addressed in a cycle SHALL hold their value.
REQ-026 enable=0 in PRIME or RUN SHALL force IDLE on the next edge, clearing all slots, strobe, ch_idx and running. Any handshake in that cycle is ignored, and rnd_ready SHALL be 0 in that cycle.
REQ-027 starve_cnt SHALL saturate at 65535.
REQ-028 clear_starve SHALL zero starve_cnt next cycle and takes priority over a simultaneous increment. starve_cnt is not cleared by IDLE.
REQ-029 All outputs SHALL be registered, except rnd_ready, which is decoded from state and enable.

Reset
REQ-030 rst SHALL asynchronously force: state IDLE, ch_idx 0, rnd_out all zero, strobe 0, running 0, starve_cnt 0.
REQ-031 On rst deassertion with enable=1, PRIME SHALL be entered on the first clk edge after deassertion.
REQ-032 rst asserted mid-RUN SHALL drop strobe and running immediately, without waiting for a clock edge.

Verification
REQ-033 NCH=4, enable=1, rnd_valid=1, rnd_in=1,2,3,4,5,... -> PRIME loads slots 0..3 with 1..3 and 4. In RUN, slot 0 <= 5 with strobe=0001 one cycle later, then slot 1 <= 6 with strobe=0010.
REQ-034 In RUN, hold rnd_valid=0 for 3 cycles -> three consecutive slots read 0, strobe keeps rotating, starve_cnt=3.
REQ-035 In PRIME, rnd_valid=0 for 5 cycles after slot 1 loads -> no advance, strobe=0, starve_cnt=0; PRIME resumes at slot 2.
REQ-036 Drop enable mid-RUN at ch_idx=2 -> next cycle IDLE: all slots 0, strobe=0, running=0. Re-enable -> PRIME starts at slot 0.
REQ-037 Preload starve_cnt to 65535 by stalling, then stall again -> stays 65535. Assert clear_starve during a stall -> starve_cnt=0.
REQ-038 Assert rst asynchronously between edges in RUN -> all outputs zero before the next edge.
